// File: rtl/dvp_rx_capture.sv
// OV5640 DVP receive front end.
// Registers the camera pins once, waits out the sensor settling frames,
// pairs bytes into RGB565 pixels, crops to an H_ACTIVE x V_ACTIVE window,
// and measures line length / line count / frame count for debug visibility.
module dvp_rx_capture #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int CNT_W       = 12,
    parameter int SKIP_FRAMES = 10
) (
    input  logic             cmos_pclk,
    input  logic             I_rst_n,
    input  logic             I_cfg_done,
    input  logic             I_err_clr,
    input  logic             cmos_vsync,
    input  logic             cmos_href,
    input  logic [7:0]       cmos_db,
    output logic [15:0]      O_pix_data,
    output logic             O_pix_valid,
    output logic             O_sof,
    output logic             O_eol,
    output logic             O_capturing,
    output logic [7:0]       O_frame_cnt,
    output logic [CNT_W-1:0] O_line_len,
    output logic [CNT_W-1:0] O_line_cnt,
    output logic             O_err_len
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SKIP    = 2'd1;
    localparam logic [1:0] ST_WAIT_VS = 2'd2;
    localparam logic [1:0] ST_ACTIVE  = 2'd3;

    localparam logic [CNT_W-1:0] H_LIM    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LIM    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       SKIP_LIM = 8'(SKIP_FRAMES);

    // Pin-side registers plus one extra stage for edge detection.
    logic       v_r, h_r, v_rr, h_rr;
    logic [7:0] d_r;

    logic [1:0]       state_reg;
    logic [7:0]       skip_cnt_reg;
    logic [CNT_W-1:0] line_idx_reg;
    logic [CNT_W-1:0] pix_idx_reg;
    logic             phase_reg;
    logic             first_pix_reg;
    logic [7:0]       hi_byte_reg;

    logic v_rise, v_fall, h_fall;
    logic in_active, pair_en, line_end, frame_end, frame_start, enter_active;
    logic in_window, fwd_pix, len_bad, cnt_bad;

    assign v_rise = v_r & ~v_rr;
    assign v_fall = ~v_r & v_rr;
    assign h_fall = ~h_r & h_rr;

    // Dropping I_cfg_done suppresses all ACTIVE-state events in that cycle too.
    assign in_active    = (state_reg == ST_ACTIVE) && I_cfg_done;
    assign pair_en      = in_active && !v_r && h_r;
    assign line_end     = in_active && !v_r && h_fall;
    assign frame_end    = in_active && v_rise;
    assign frame_start  = in_active && v_fall;
    assign enter_active = (state_reg == ST_WAIT_VS) && I_cfg_done && v_fall;

    assign in_window = (pix_idx_reg < H_LIM) && (line_idx_reg < V_LIM);
    assign fwd_pix   = pair_en && phase_reg && in_window;
    assign len_bad   = line_end && ((pix_idx_reg != H_LIM) || phase_reg);
    assign cnt_bad   = frame_end && (line_idx_reg != V_LIM);

    assign O_capturing = (state_reg == ST_ACTIVE);

    // Single register stage on the camera pins; everything downstream uses these.
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            v_r  <= 1'b0;
            h_r  <= 1'b0;
            v_rr <= 1'b0;
            h_rr <= 1'b0;
            d_r  <= 8'd0;
        end else begin
            v_r  <= cmos_vsync;
            h_r  <= cmos_href;
            d_r  <= cmos_db;
            v_rr <= v_r;
            h_rr <= h_r;
        end
    end

    // Capture sequencing: settle-frame skip, then align to a frame start.
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg    <= ST_IDLE;
            skip_cnt_reg <= 8'd0;
        end else if (!I_cfg_done) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg    <= ST_SKIP;
                    skip_cnt_reg <= 8'd0;
                end
                ST_SKIP: begin
                    if (skip_cnt_reg == SKIP_LIM)
                        state_reg <= ST_WAIT_VS;
                    else if (v_rise)
                        skip_cnt_reg <= skip_cnt_reg + 8'd1;
                end
                ST_WAIT_VS: begin
                    if (v_fall)
                        state_reg <= ST_ACTIVE;
                end
                default: state_reg <= state_reg;
            endcase
        end
    end

    // Byte pairing and in-line pixel index; both reset at every line end.
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pix_idx_reg <= '0;
            phase_reg   <= 1'b0;
            hi_byte_reg <= 8'd0;
        end else if (!I_cfg_done || line_end || frame_start) begin
            pix_idx_reg <= '0;
            phase_reg   <= 1'b0;
        end else if (pair_en) begin
            phase_reg <= ~phase_reg;
            if (!phase_reg)
                hi_byte_reg <= d_r;
            else if (pix_idx_reg != CNT_MAX)
                pix_idx_reg <= pix_idx_reg + 1'b1;
        end
    end

    // Line index within the frame and the pending start-of-frame marker.
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            line_idx_reg  <= '0;
            first_pix_reg <= 1'b0;
        end else if (!I_cfg_done) begin
            line_idx_reg  <= '0;
            first_pix_reg <= 1'b0;
        end else if (enter_active || frame_start) begin
            line_idx_reg  <= '0;
            first_pix_reg <= 1'b1;
        end else begin
            if (line_end && (line_idx_reg != CNT_MAX))
                line_idx_reg <= line_idx_reg + 1'b1;
            if (fwd_pix)
                first_pix_reg <= 1'b0;
        end
    end

    // Pixel output strobes; data holds its last value between strobes.
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_pix_data  <= 16'd0;
            O_pix_valid <= 1'b0;
            O_sof       <= 1'b0;
            O_eol       <= 1'b0;
        end else begin
            O_pix_valid <= fwd_pix;
            O_sof       <= fwd_pix && first_pix_reg;
            O_eol       <= fwd_pix && (pix_idx_reg == H_LAST);
            if (fwd_pix)
                O_pix_data <= {hi_byte_reg, d_r};
        end
    end

    // Measured geometry and the sticky format error (a new error beats a clear).
    always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_frame_cnt <= 8'd0;
            O_line_len  <= '0;
            O_line_cnt  <= '0;
            O_err_len   <= 1'b0;
        end else begin
            if (line_end)
                O_line_len <= pix_idx_reg;
            if (frame_end) begin
                O_line_cnt  <= line_idx_reg;
                O_frame_cnt <= O_frame_cnt + 8'd1;
            end
            if (len_bad || cnt_bad)
                O_err_len <= 1'b1;
            else if (I_err_clr)
                O_err_len <= 1'b0;
        end
    end

endmodule

// File: doc/dvp_rx_capture.md
Name: dvp_rx_capture

Overview:
- Receive side of the OV5640 DVP pixel bus.
- Samples cmos_vsync, cmos_href and cmos_db in the camera pixel-clock domain.
- Pairs bytes into RGB565 pixels, crops each frame to the configured window and flags frame/line boundaries.
- Measures the incoming line length, line count and frame count, and flags malformed lines for PMOD/UART debug.
- Sits between the camera pins and the frame-buffer write path (DDR3 side).

Parameters:
- H_ACTIVE, 1280, pixels per line forwarded; also the expected line length.
- V_ACTIVE, 720, lines per frame forwarded; also the expected line count.
- CNT_W, 12, width of the pixel and line counters.
- SKIP_FRAMES, 10, frames discarded after I_cfg_done rises (sensor settling). Valid range 0-255.

Ports:
- cmos_pclk  in  1  pixel clock, ~42 MHz, rising-edge.
- I_rst_n  in  1  reset.
- I_cfg_done  in  1  SCCB configuration complete, level, synchronous to cmos_pclk.
- I_err_clr  in  1  one-cycle pulse; clears O_err_len.
- cmos_vsync  in  1  frame sync, active high (high = vertical blanking).
- cmos_href  in  1  line valid, active high.
- cmos_db  in  8  pixel byte; high byte first.
- O_pix_data  out  16  RGB565 pixel {hi_byte, lo_byte}.
- O_pix_valid  out  1  one-cycle strobe per forwarded pixel.
- O_sof  out  1  with O_pix_valid on pixel (0,0) of a frame.
- O_eol  out  1  with O_pix_valid on pixel H_ACTIVE-1 of every forwarded line.
- O_capturing  out  1  high in state ACTIVE.
- O_frame_cnt  out  8  completed frames in ACTIVE, wraps.
- O_line_len  out  CNT_W  pixel count of the last completed line.
- O_line_cnt  out  CNT_W  line count of the last completed frame.
- O_err_len  out  1  sticky line-format error.

Behaviour:
- Reset: I_rst_n, asynchronous, active-low; clock cmos_pclk. All outputs and internal registers are 0 while reset is asserted; state is IDLE.
- Input stage: vsync, href and db are registered once (v_r, h_r, d_r). All logic uses the registered copies.
- Latency: a byte present on pins at edge E is in d_r from edge E. The resulting pixel's outputs update at edge E+1.
- State IDLE: wait for I_cfg_done=1, then go to SKIP with skip_cnt=0.
- State SKIP:
  - Each v_r rising edge increments skip_cnt.
  - When skip_cnt==SKIP_FRAMES, go to WAIT_VS. With SKIP_FRAMES=0, go to WAIT_VS on the cycle after entry.
- State WAIT_VS: on a v_r falling edge, go to ACTIVE. line_idx=0, first_pix=1.
- State ACTIVE:
  - A v_r rising edge ends the frame: O_line_cnt<=line_idx; O_frame_cnt++; if line_idx!=V_ACTIVE set O_err_len.
  - A v_r falling edge starts the next frame: line_idx=0, first_pix=1. The state stays ACTIVE.
- I_cfg_done=0 in any state: go to IDLE next cycle. Pair and pixel counters clear; measured outputs and O_frame_cnt hold.
- Byte pairing (ACTIVE, v_r=0, h_r=1):
  - A phase bit toggles every cycle. Phase 0 stores the high byte; phase 1 forms the pixel.
  - pix_idx increments per pixel and saturates at all-ones.
- Forwarding rule: O_pix_valid=1 only when pix_idx<H_ACTIVE and line_idx<V_ACTIVE. Pixels outside this window are counted but not forwarded.
- O_sof=1 on the first forwarded pixel after first_pix is set; first_pix then clears. O_eol=1 when pix_idx==H_ACTIVE-1.
- Line end (h_r falling edge in ACTIVE with v_r=0):
  - O_line_len<=pix_idx.
  - If pix_idx!=H_ACTIVE, or the phase bit is 1 (orphan byte, dropped), set O_err_len.
  - line_idx++ (saturating), pix_idx=0, phase=0.
- href high in any state other than ACTIVE, or while v_r=1: ignored, no pixels forwarded, no counting.
- O_err_len: sticky; cleared by I_err_clr. If a set event and I_err_clr occur in the same cycle, the set wins.
- Reset mid-line: outputs drop immediately. After release the block re-runs IDLE→SKIP, so a partial frame is never forwarded.

Test Plan:
- SKIP_FRAMES=2, H_ACTIVE=8, V_ACTIVE=4; raise I_cfg_done; drive 4 well-formed frames of 4 lines × 16 bytes (bytes incrementing 0x00..) → no O_pix_valid during frames 1-2. Frames 3-4 each give 32 strobes; the first has O_sof=1 and O_pix_data=16'h0001. O_frame_cnt ends at 2. O_line_len=8, O_line_cnt=4, O_err_len=0.
- One line of 10 pixels (20 bytes) in a frame → only 8 forwarded, O_eol on the 8th. O_line_len=10, O_err_len=1. I_err_clr pulse → 0.
- Line with 15 bytes → 7 pixels forwarded, orphan dropped, O_err_len=1, O_line_len=7.
- Frame of 6 lines → lines 4-5 produce no strobes. O_line_cnt=6, O_err_len=1.
- Pixel-level latency check: low byte on pins at edge E → O_pix_valid high after edge E+1 for exactly one cycle. href pulse while vsync=1 → no strobes.
- Assert I_rst_n=0 mid-line in ACTIVE → all outputs 0 asynchronously. After release with I_cfg_done=1, SKIP_FRAMES frames are skipped before O_sof reappears. I_cfg_done dropped mid-frame → O_capturing=0 the next cycle.
